// File: rtl/b_reg_if.sv
// Bus bundle for the NSC-8 B operand register: two load strobes, data bus in, and register contents out.
interface b_reg_if #(
    parameter int N = 8
);
    logic         load_immediate_b;
    logic         load_b;
    logic [N-1:0] data_in;
    logic [N-1:0] data_out;

    // There is no valid/ready handshake. A load strobe is a one-cycle command
    // that is sampled on the rising clk edge together with data_in. data_out
    // shows the result from the following edge onward and is always valid.
    modport master (
        output load_immediate_b,
        output load_b,
        output data_in,
        input  data_out
    );

    modport slave (
        input  load_immediate_b,
        input  load_b,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/b_reg.sv
// B operand register for the NSC-8 ALU: loads the full bus word or the zero-extended immediate field.
module b_reg #(
    parameter int N     = 8,
    parameter int IMM_W = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    b_reg_if.slave  bus
);
    logic [N-1:0] b_q;
    logic [N-1:0] imm_ext;

    // The upper bits are cleared on an immediate load, so the register never
    // holds a mix of old and new data.
    assign imm_ext = {{(N-IMM_W){1'b0}}, bus.data_in[IMM_W-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q <= '0;
        end else if (bus.load_b) begin
            b_q <= bus.data_in;
        end else if (bus.load_immediate_b) begin
            b_q <= imm_ext;
        end
    end

    assign bus.data_out = b_q;
endmodule

// File: tb/tb_b_reg.sv
// Directed bench for b_reg: a table of single-edge vectors followed by short multi-cycle sequences.
module tb_b_reg;
    localparam int N     = 8;
    localparam int IMM_W = 4;

    typedef struct {
        string        name;
        logic         rst_n;
        logic         ld_b;
        logic         ld_imm;
        logic [N-1:0] din;
        logic [N-1:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;

    b_reg_if #(.N(N)) bus ();

    b_reg #(.N(N), .IMM_W(IMM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard.
    logic [N-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    task automatic compare(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: data_out=%h expected=%h", name, act, exp);
        end
    endtask

    // Driver tasks.
    task automatic drive(input logic r, input logic lb, input logic li, input logic [N-1:0] d);
        rst_n                = r;
        bus.load_b           = lb;
        bus.load_immediate_b = li;
        bus.data_in          = d;
    endtask

    // Drive one edge's worth of inputs and check data_out half a cycle after the edge.
    task automatic step(input string name, input logic r, input logic lb, input logic li,
                        input logic [N-1:0] d, input logic [N-1:0] exp);
        logic [N-1:0] e;
        drive(r, lb, li, d);
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        compare(name, bus.data_out, e);
    endtask

    function automatic void add_vec(input string name, input logic r, input logic lb, input logic li,
                                    input logic [N-1:0] d, input logic [N-1:0] exp);
        vec_t v;
        v.name = name; v.rst_n = r; v.ld_b = lb; v.ld_imm = li; v.din = d; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        //      name              rst lb li  data   expected
        add_vec("reset_over_load", 0, 1, 0, 8'hFF, 8'h00);
        add_vec("reset_release",   1, 0, 0, 8'hFF, 8'h00);
        add_vec("load_full_ff",    1, 1, 0, 8'hFF, 8'hFF);
        add_vec("hold_din_3c",     1, 0, 0, 8'h3C, 8'hFF);
        add_vec("imm_clears_high", 1, 0, 1, 8'hFF, 8'h0F);
        add_vec("hold_after_imm",  1, 0, 0, 8'hFF, 8'h0F);
        add_vec("both_load_b_win", 1, 1, 1, 8'hA5, 8'hA5);
        add_vec("imm_5a",          1, 0, 1, 8'h5A, 8'h0A);
        add_vec("load_full_a5",    1, 1, 0, 8'hA5, 8'hA5);
        add_vec("reset_drops_ld",  0, 1, 0, 8'h77, 8'h00);
        add_vec("load_full_80",    1, 1, 0, 8'h80, 8'h80);
        add_vec("imm_zero_nibble", 1, 0, 1, 8'h30, 8'h00);
        add_vec("load_full_7e",    1, 1, 0, 8'h7E, 8'h7E);
        add_vec("imm_7e",          1, 0, 1, 8'h7E, 8'h0E);
        add_vec("reset_over_imm",  0, 0, 1, 8'hFF, 8'h00);
        add_vec("hold_zero",       1, 0, 0, 8'hC3, 8'h00);

        drive(1'b0, 1'b0, 1'b0, '0);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst_n, vecs[i].ld_b, vecs[i].ld_imm, vecs[i].din, vecs[i].exp);
        end

        // Back-to-back full load, immediate load, hold.
        step("seq_load_12", 1, 1, 0, 8'h12, 8'h12);
        step("seq_imm_f7",  1, 0, 1, 8'hF7, 8'h07);
        step("seq_hold",    1, 0, 0, 8'hF7, 8'h07);

        // A pending load must not reach data_out before the clock edge.
        drive(1'b1, 1'b1, 1'b0, 8'hFF);
        #1;
        compare("no_comb_path", bus.data_out, 8'h07);
        @(posedge clk);
        @(negedge clk);
        compare("pending_load_lands", bus.data_out, 8'hFF);

        // Held value survives several cycles of bus noise with no load.
        for (int k = 0; k < 4; k++) begin
            step("hold_noise", 1, 0, 0, N'($urandom_range(0, 255)), 8'hFF);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
